mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Multi-cycle controller and datapath for the RV32M MUL instruction (low 32 bits of rs1*rs2). Uses an iterative shift-add, one bit per cycle.
- Sits in EX beside the single-cycle ALU and its control decoder.
- Decodes func7/func3 itself, holds the pipeline via stall_o while iterating, and presents a one-cycle done pulse with the result.

Parameters:
- DATA_W, 32, operand/result width in bits; multiplier bits consumed one per cycle.
- CNT_W, $clog2(DATA_W)+1, iteration counter width.

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  EX holds a valid R-type instruction this cycle.
- func7_i  input  7  instruction funct7.
- func3_i  input  3  instruction funct3.
- rs1_data_i  input  DATA_W  multiplicand.
- rs2_data_i  input  DATA_W  multiplier.
- flush_i  input  1  pipeline flush; abandons any in-flight multiply.
- busy_o  output  1  multiply in progress (RUN state).
- stall_o  output  1  hold PC/IF/ID/EX this cycle.
- done_o  output  1  one-cycle pulse; result_o valid.
- result_o  output  DATA_W  product[DATA_W-1:0].

Behaviour:
- Reset (rst_i low, async): state=IDLE; busy_o=0, done_o=0, result_o=0, acc=0, mcand=0, mplier=0, count=0. stall_o is combinational, so it is 0 while in reset.
- Accept condition: state==IDLE && start_i && !flush_i && func7_i==7'b0000001 && func3_i==3'b000. Any other func7/func3 is never accepted, so non-MUL ops pass through untouched.
- IDLE:
  - On accept: mcand<=rs1_data_i, mplier<=rs2_data_i, acc<=0, count<=0, go RUN.
  - stall_o=1 combinationally in the accept cycle. Otherwise stall_o=0.
- RUN:
  - Each cycle: if mplier[0], acc<=acc+mcand (mod 2^DATA_W, carry discarded).
  - mcand<=mcand<<1; mplier<=mplier>>1 (logical); count<=count+1.
  - After exactly DATA_W RUN cycles (count==DATA_W-1 this cycle), go DONE and result_o<=final acc.
  - busy_o=1, stall_o=1 throughout.
- DONE:
  - done_o=1, busy_o=0, stall_o=0 for exactly one cycle, so the pipeline advances and EX/MEM latches result_o. Next state IDLE.
  - No new start accepted in DONE. A MUL immediately following is accepted in the next IDLE cycle.
- Fixed latency: accept at cycle T; RUN cycles T+1..T+DATA_W; done_o high at T+DATA_W+1. No early termination, even for zero operands.
- result_o holds its value after DONE until the next DONE. It is not cleared on accept or on flush.
- flush_i:
  - In RUN or DONE: next state IDLE, no done pulse, result_o unchanged.
  - flush_i in the same cycle as start_i in IDLE: not accepted.
  - stall_o drops to 0 in the flush cycle.
- start_i while in RUN or DONE: ignored; operand registers are not disturbed.
- Reset asserted mid-RUN: immediate return to IDLE with all registers cleared; no done pulse.
- Signedness: the low-half product is identical for signed and unsigned operands, so no sign handling.

Decomposition:
- Shared package mul_pkg:
  - state enum IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Constants FUNCT7_MULDIV=7'b0000001, FUNCT3_MUL=3'b000.
- One sub-module, mul_shift_add_dp:
  - Holds the acc/mcand/mplier registers and adder.
  - Inputs load, step, and operands; output acc.
- The FSM, counter and decode remain in mul_sequencer.

Test Plan:
- Basic: rs1=3, rs2=5, MUL start at cycle T -> stall_o=1 from T..T+32, done_o=1 and result_o=15 at T+33, stall_o=0 at T+33.
- Wrap: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result_o=0x00000001. Also rs1=0x00010000, rs2=0x00010000 -> result_o=0x00000000.
- Decode: func7=0000000/func3=000 (ADD), and func7=0000001/func3=001 (MULH) with start_i=1 -> stall_o=0, busy_o=0, no done. Back-to-back MULs (7*6, then 9*9) -> 42 and 81 with exactly one IDLE cycle between them.
- Flush: rs1=3, rs2=5, flush_i pulsed at T+10 -> IDLE at T+11, no done_o, result_o keeps its prior value (e.g. 81). start+flush in the same IDLE cycle -> not accepted.
- Reset: rst_i low at T+20 mid-RUN -> immediately busy_o=0, stall_o=0, result_o=0. After release, rs1=2, rs2=4 -> result_o=8 after 33 cycles.
- Operand stability: rs1/rs2 changed to 0x1234 during RUN (start_i high) -> result of the originally latched operands is unaffected.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative RV32M MUL unit.
// This package holds the FSM state encoding and the instruction decode constants.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_MUL    = 3'b000;

    function automatic logic is_mul(input logic [6:0] func7, input logic [2:0] func3);
        return (func7 == FUNCT7_MULDIV) && (func3 == FUNCT3_MUL);
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: consumes one multiplier bit per step.
// acc_next is the accumulator value after the current step and is the product on the last step.
module mul_shift_add_dp
    import mul_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] acc_next
);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;

    // Carry out of the top bit is dropped: only the low half of the product is kept.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle RV32M MUL controller for the EX stage.
// It decodes MUL, stalls the pipeline for DATA_W iterations, and then pulses done_o with the result.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [6:0]        func7_i,
    input  logic [2:0]        func3_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    mul_state_t        state;
    mul_state_t        state_next;
    logic [CNT_W-1:0]  count;
    logic              accept;
    logic              last_step;
    logic              load;
    logic              step;
    logic [DATA_W-1:0] acc_next;

    assign accept    = (state == IDLE) && start_i && !flush_i && is_mul(func7_i, func3_i);
    assign last_step = (count == CNT_W'(DATA_W - 1));

    assign busy_o = (state == RUN);
    // A flush in the DONE cycle means the MUL itself is squashed, so its pulse is withheld.
    assign done_o = (state == DONE) && !flush_i;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        stall_o    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                    load       = 1'b1;
                    stall_o    = 1'b1;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
                    step    = 1'b1;
                    stall_o = 1'b1;
                    if (last_step) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            count    <= '0;
            result_o <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                count <= '0;
            end else if (step) begin
                count <= count + CNT_W'(1);
            end
            if (step && last_step) begin
                result_o <= acc_next;
            end
        end
    end

    mul_shift_add_dp #(
        .DATA_W(DATA_W)
    ) u_dp (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .load     (load),
        .step     (step),
        .op_a     (rs1_data_i),
        .op_b     (rs2_data_i),
        .acc_next (acc_next)
    );

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and randomized bench for mul_sequencer.
// Expected products come from 64-bit arithmetic, and expected timing comes from the fixed 33-cycle latency.
module tb_mul_sequencer;

    localparam int unsigned DATA_W = 32;
    localparam logic [6:0]  F7_MUL = 7'b0000001;
    localparam logic [2:0]  F3_MUL = 3'b000;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [6:0]        func7_i;
    logic [2:0]        func3_i;
    logic [DATA_W-1:0] rs1_data_i;
    logic [DATA_W-1:0] rs2_data_i;
    logic              flush_i;
    logic              busy_o;
    logic              stall_o;
    logic              done_o;
    logic [DATA_W-1:0] result_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] last_result = '0;

    always #5 clk = ~clk;

    mul_sequencer #(
        .DATA_W(DATA_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .func7_i    (func7_i),
        .func3_i    (func3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a MUL in IDLE and advances into the first RUN cycle.
    task automatic start_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
        start_i    = 1'b1;
        func7_i    = F7_MUL;
        func3_i    = F3_MUL;
        rs1_data_i = a;
        rs2_data_i = b;
        #1;
        check({tag, "_accept_stall"}, 32'(stall_o), 32'd1);
        tick();
        start_i = 1'b0;
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit scramble, input string tag);
        logic [31:0] exp;
        exp = mul_ref(a, b);
        start_mul(a, b, tag);
        if (scramble) begin
            start_i    = 1'b1;
            rs1_data_i = 32'h1234;
            rs2_data_i = 32'h1234;
        end else begin
            rs1_data_i = $urandom;
            rs2_data_i = $urandom;
        end
        for (int k = 1; k <= 32; k++) begin
            check({tag, "_run_busy"}, 32'(busy_o), 32'd1);
            check({tag, "_run_stall"}, 32'(stall_o), 32'd1);
            check({tag, "_run_nodone"}, 32'(done_o), 32'd0);
            tick();
        end
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_result"}, result_o, exp);
        check({tag, "_done_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_done_busy"}, 32'(busy_o), 32'd0);
        tick();
        start_i = 1'b0;
        #1;
        check({tag, "_idle_done"}, 32'(done_o), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_idle_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_hold"}, result_o, exp);
        last_result = exp;
    endtask

    task automatic no_accept(input logic [6:0] f7, input logic [2:0] f3, input logic fl, input string tag);
        start_i    = 1'b1;
        func7_i    = f7;
        func3_i    = f3;
        flush_i    = fl;
        rs1_data_i = 32'd7;
        rs2_data_i = 32'd7;
        #1;
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        tick();
        start_i = 1'b0;
        flush_i = 1'b0;
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        for (int k = 0; k < 34; k++) begin
            check({tag, "_nodone"}, 32'(done_o), 32'd0);
            tick();
        end
        check({tag, "_result"}, result_o, last_result);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  f7;
        logic [2:0]  f3;

        rst_i      = 1'b0;
        start_i    = 1'b0;
        func7_i    = '0;
        func3_i    = '0;
        rs1_data_i = '0;
        rs2_data_i = '0;
        flush_i    = 1'b0;
        #1;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_stall", 32'(stall_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        tick();
        tick();
        rst_i = 1'b1;

        do_mul(32'd3, 32'd5, 1'b0, "basic");
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "wrap_ones");
        do_mul(32'h0001_0000, 32'h0001_0000, 1'b0, "wrap_zero");
        do_mul(32'd0, 32'd12345, 1'b0, "zero_op");

        no_accept(7'b0000000, 3'b000, 1'b0, "dec_add");
        no_accept(7'b0000001, 3'b001, 1'b0, "dec_mulh");

        do_mul(32'd7, 32'd6, 1'b0, "b2b_first");
        do_mul(32'd9, 32'd9, 1'b0, "b2b_second");

        // A flush in the tenth RUN cycle abandons the multiply and leaves the previous result in place.
        start_mul(32'd3, 32'd5, "flush");
        repeat (9) tick();
        flush_i = 1'b1;
        #1;
        check("flush_stall", 32'(stall_o), 32'd0);
        check("flush_busy", 32'(busy_o), 32'd1);
        tick();
        flush_i = 1'b0;
        check("flush_idle", 32'(busy_o), 32'd0);
        for (int k = 0; k < 34; k++) begin
            check("flush_nodone", 32'(done_o), 32'd0);
            tick();
        end
        check("flush_result", result_o, last_result);

        no_accept(F7_MUL, F3_MUL, 1'b1, "start_flush");

        do_mul(32'hDEAD_BEEF, 32'h0000_0013, 1'b1, "stable");

        start_mul(32'd11, 32'd13, "rst");
        repeat (19) tick();
        rst_i = 1'b0;
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        tick();
        tick();
        rst_i = 1'b1;
        last_result = '0;
        tick();
        check("rst_after_busy", 32'(busy_o), 32'd0);
        do_mul(32'd2, 32'd4, 1'b0, "post_rst");

        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 3) b = 32'h8000_0000;
            if (i == 6) a = 32'h0000_0001;
            do_mul(a, b, 1'($urandom_range(0, 1)), "rand");
            f7 = 7'($urandom);
            f3 = 3'($urandom);
            if (f7 == F7_MUL && f3 == F3_MUL) f3 = 3'b100;
            start_i    = 1'b1;
            func7_i    = f7;
            func3_i    = f3;
            #1;
            check("rand_dec_stall", 32'(stall_o), 32'd0);
            tick();
            start_i = 1'b0;
            check("rand_dec_busy", 32'(busy_o), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
